// File: rtl/gate_bist_checker.sv
// Built-in self-test engine for one 2-input gate: walks {a,b} = 0..3, compares the
// gate output with the selected truth table. Optional macro GATE_BIST_SYNC_EN adds a 2-flop input synchronizer.
module gate_bist_checker #(
    parameter int SETTLE_CYCLES = 4,
    parameter int ERR_W         = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       func_sel,
    output logic             dut_a,
    output logic             dut_b,
    input  logic             dut_c,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_cnt,
    output logic [3:0]       fail_vec,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

`ifdef GATE_BIST_SYNC_EN
    // Two extra settle cycles cover the synchronizer latency.
    localparam int SETTLE_TOTAL = SETTLE_CYCLES + 2;
`else
    localparam int SETTLE_TOTAL = SETTLE_CYCLES;
`endif
    localparam int CNT_W = $clog2(SETTLE_TOTAL + 1);

    state_t             state_q;
    logic [1:0]         idx_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [1:0]         sel_q;
    logic               dut_a_q, dut_b_q;
    logic               busy_q, done_q, pass_q;
    logic [ERR_W-1:0]   err_cnt_q, err_cnt_d;
    logic [3:0]         fail_vec_q, fail_vec_d;
    logic               c_cmp;
    logic               exp_bit;
    logic               vec_a, vec_b;

`ifdef GATE_BIST_SYNC_EN
    logic sync1_q, sync2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= dut_c;
            sync2_q <= sync1_q;
        end
    end

    assign c_cmp = sync2_q;
`else
    assign c_cmp = dut_c;
`endif

    assign vec_a = idx_q[1];
    assign vec_b = idx_q[0];

    always_comb begin
        exp_bit    = 1'b0;
        fail_vec_d = fail_vec_q;
        err_cnt_d  = err_cnt_q;
        case (sel_q)
            2'b00:   exp_bit = vec_a | vec_b;
            2'b01:   exp_bit = vec_a & vec_b;
            2'b10:   exp_bit = ~(vec_a | vec_b);
            default: exp_bit = vec_a ^ vec_b;
        endcase
        if (c_cmp != exp_bit) begin
            fail_vec_d[idx_q] = 1'b1;
            // Saturate rather than wrap so a full count never reads as a small one.
            if (err_cnt_q != {ERR_W{1'b1}}) begin
                err_cnt_d = err_cnt_q + ERR_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            idx_q      <= 2'd0;
            cnt_q      <= '0;
            sel_q      <= 2'b00;
            dut_a_q    <= 1'b0;
            dut_b_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            err_cnt_q  <= '0;
            fail_vec_q <= 4'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        state_q    <= SETTLE;
                        idx_q      <= 2'd0;
                        cnt_q      <= '0;
                        sel_q      <= func_sel;
                        err_cnt_q  <= '0;
                        fail_vec_q <= 4'd0;
                        pass_q     <= 1'b0;
                        busy_q     <= 1'b1;
                        dut_a_q    <= 1'b0;
                        dut_b_q    <= 1'b0;
                    end
                end
                SETTLE: begin
                    if (cnt_q == CNT_W'(SETTLE_TOTAL - 1)) begin
                        state_q <= SAMPLE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                SAMPLE: begin
                    fail_vec_q <= fail_vec_d;
                    err_cnt_q  <= err_cnt_d;
                    if (idx_q != 2'd3) begin
                        state_q              <= SETTLE;
                        idx_q                <= idx_q + 2'd1;
                        {dut_a_q, dut_b_q}   <= idx_q + 2'd1;
                        cnt_q                <= '0;
                    end else begin
                        state_q <= DONE;
                        dut_a_q <= 1'b0;
                        dut_b_q <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        pass_q  <= (fail_vec_d == 4'd0);
                    end
                end
                default: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign dut_a     = dut_a_q;
    assign dut_b     = dut_b_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign err_cnt   = err_cnt_q;
    assign fail_vec  = fail_vec_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_gate_bist_checker.sv
// Bench for gate_bist_checker: a default instance and an ERR_W=1 instance run in lockstep,
// each driving its own behavioural gate model.
module tb_gate_bist_checker;

`ifdef GATE_BIST_SYNC_EN
  localparam int HOLD = 4 + 3;
`else
  localparam int HOLD = 4 + 1;
`endif
  localparam int LAT = 4 * HOLD;
  localparam int TMO = 200;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [1:0] func_sel = 2'b00;

  logic       a0, b0, c0, busy0, done0, pass0;
  logic [2:0] err_cnt0;
  logic [3:0] fail_vec0;
  logic [1:0] st0;
  logic       a1, b1, c1, busy1, done1, pass1;
  logic [0:0] err_cnt1;
  logic [3:0] fail_vec1;
  logic [1:0] st1;

  // Physical gate behaviour as a truth table indexed by {a,b}.
  logic [3:0] phys0 = 4'b1110;
  logic [3:0] phys1 = 4'b1110;
  assign c0 = phys0[{a0, b0}];
  assign c1 = phys1[{a1, b1}];

  logic [7:0] got0, got1;
  assign got0 = {pass0, err_cnt0, fail_vec0};
  assign got1 = {pass1, 2'b00, err_cnt1, fail_vec1};

  logic [7:0] exp_q[$];
  logic [7:0] exp_q1[$];
  int total = 0;
  int bad = 0;
  int vec_hold[4];
  int busy_gaps;

  gate_bist_checker #(.SETTLE_CYCLES(4), .ERR_W(3)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .func_sel(func_sel),
    .dut_a(a0), .dut_b(b0), .dut_c(c0), .busy(busy0), .done(done0),
    .pass(pass0), .err_cnt(err_cnt0), .fail_vec(fail_vec0), .dbg_state(st0)
  );

  gate_bist_checker #(.SETTLE_CYCLES(4), .ERR_W(1)) u_dut_e1 (
    .clk(clk), .rst_n(rst_n), .start(start), .func_sel(func_sel),
    .dut_a(a1), .dut_b(b1), .dut_c(c1), .busy(busy1), .done(done1),
    .pass(pass1), .err_cnt(err_cnt1), .fail_vec(fail_vec1), .dbg_state(st1)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] predict(input logic [1:0] sel, input logic [3:0] phys, input int maxc);
    logic [3:0] tbl;
    logic [3:0] fv;
    int cnt;
    case (sel)
      2'b00: tbl = 4'b1110;
      2'b01: tbl = 4'b1000;
      2'b10: tbl = 4'b0001;
      default: tbl = 4'b0110;
    endcase
    fv = tbl ^ phys;
    cnt = 0;
    for (int v = 0; v < 4; v++) if (fv[v]) cnt++;
    if (cnt > maxc) cnt = maxc;
    return {(fv == 4'd0), cnt[2:0], fv};
  endfunction

  task automatic launch(input logic [1:0] sel, input bit hold);
    @(negedge clk);
    start = 1'b1;
    func_sel = sel;
    exp_q.push_back(predict(sel, phys0, 7));
    exp_q1.push_back(predict(sel, phys1, 1));
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
  endtask

  // act: 0 none, 1 invert func_sel, 2 one-cycle start pulse; applied at negedge act_at.
  task automatic wait_done(output int n, input int act_at, input int act);
    n = -1;
    busy_gaps = 0;
    for (int v = 0; v < 4; v++) vec_hold[v] = 0;
    for (int i = 0; i < TMO; i++) begin
      @(negedge clk);
      if (done0) begin
        n = i;
        break;
      end
      if (busy0) vec_hold[{a0, b0}]++;
      else busy_gaps++;
      if (i == act_at && act == 1) func_sel = ~func_sel;
      if (i == act_at && act == 2) start = 1'b1;
      if (i == act_at + 1 && act == 2) start = 1'b0;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    @(negedge clk);
    total++;
    if ({busy0, done0, pass0, err_cnt0, fail_vec0, a0, b0, st0} !== 13'd0) begin
      bad++;
      $display("FAIL reset_inst0 got=%b want=0", {busy0, done0, pass0, err_cnt0, fail_vec0, a0, b0, st0});
    end
    total++;
    if ({busy1, done1, pass1, err_cnt1, fail_vec1, a1, b1, st1} !== 11'd0) begin
      bad++;
      $display("FAIL reset_inst1 got=%b want=0", {busy1, done1, pass1, err_cnt1, fail_vec1, a1, b1, st1});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_or_ideal;
    int n;
    logic [7:0] e0, e1;
    phys0 = 4'b1110;
    phys1 = 4'b1110;
    launch(2'b00, 1'b0);
    total++;
    if ({busy0, a0, b0} !== 3'b100) begin
      bad++;
      $display("FAIL or_first_cycle got busy,a,b=%b want=100", {busy0, a0, b0});
    end
    wait_done(n, -1, 0);
    total++;
    if (n != LAT) begin bad++; $display("FAIL or_latency got=%0d want=%0d", n, LAT); end
    for (int v = 0; v < 4; v++) begin
      total++;
      if (vec_hold[v] != HOLD) begin
        bad++;
        $display("FAIL or_hold_vec%0d got=%0d want=%0d", v, vec_hold[v], HOLD);
      end
    end
    total++;
    if (busy_gaps != 0) begin bad++; $display("FAIL or_busy_gap got=%0d want=0", busy_gaps); end
    e0 = exp_q.pop_front();
    e1 = exp_q1.pop_front();
    total++;
    if (got0 !== e0) begin bad++; $display("FAIL or_result0 got=%b want=%b", got0, e0); end
    total++;
    if (got1 !== e1) begin bad++; $display("FAIL or_result1 got=%b want=%b", got1, e1); end
    total++;
    if ({busy0, a0, b0, done1} !== 4'b0001) begin
      bad++;
      $display("FAIL or_done_cycle got busy,a,b,done1=%b want=0001", {busy0, a0, b0, done1});
    end
    @(negedge clk);
    total++;
    if ({done0, got0} !== {1'b0, e0}) begin
      bad++;
      $display("FAIL or_held got=%b want=%b", {done0, got0}, {1'b0, e0});
    end
  endtask

  task automatic test_stuck0;
    int n;
    logic [7:0] e0, e1;
    phys0 = 4'b0000;
    phys1 = 4'b0000;
    launch(2'b00, 1'b0);
    wait_done(n, -1, 0);
    e0 = exp_q.pop_front();
    e1 = exp_q1.pop_front();
    total++;
    if (n != LAT) begin bad++; $display("FAIL stuck0_latency got=%0d want=%0d", n, LAT); end
    total++;
    if (got0 !== e0) begin bad++; $display("FAIL stuck0_result0 got=%b want=%b", got0, e0); end
    total++;
    if (got1 !== e1) begin bad++; $display("FAIL stuck0_result1 got=%b want=%b", got1, e1); end
  endtask

  task automatic test_func_change;
    int n;
    logic [7:0] e0, e1;
    phys0 = 4'b1110;
    phys1 = 4'b1110;
    launch(2'b01, 1'b0);
    wait_done(n, 6, 1);
    e0 = exp_q.pop_front();
    e1 = exp_q1.pop_front();
    total++;
    if (got0 !== e0) begin bad++; $display("FAIL func_change_result0 got=%b want=%b", got0, e0); end
    total++;
    if (got1 !== e1) begin bad++; $display("FAIL func_change_result1 got=%b want=%b", got1, e1); end
  endtask

  task automatic test_saturation;
    int n;
    logic [7:0] e0, e1;
    phys0 = 4'b1111;
    phys1 = 4'b1111;
    launch(2'b01, 1'b0);
    wait_done(n, -1, 0);
    e0 = exp_q.pop_front();
    e1 = exp_q1.pop_front();
    total++;
    if (got0 !== e0) begin bad++; $display("FAIL sat_result0 got=%b want=%b", got0, e0); end
    total++;
    if (got1 !== e1) begin bad++; $display("FAIL sat_result1 got=%b want=%b", got1, e1); end
  endtask

  task automatic test_nor_xor;
    int n;
    logic [7:0] e0, e1;
    phys0 = 4'b1110;
    phys1 = 4'b1110;
    for (int s = 2; s < 4; s++) begin
      launch(s[1:0], 1'b0);
      wait_done(n, -1, 0);
      e0 = exp_q.pop_front();
      e1 = exp_q1.pop_front();
      total++;
      if (got0 !== e0) begin bad++; $display("FAIL sel%0d_result0 got=%b want=%b", s, got0, e0); end
      total++;
      if (got1 !== e1) begin bad++; $display("FAIL sel%0d_result1 got=%b want=%b", s, got1, e1); end
    end
  endtask

  task automatic test_busy_restart;
    int n;
    logic [7:0] e0;
    phys0 = 4'b1110;
    phys1 = 4'b1110;
    launch(2'b00, 1'b0);
    wait_done(n, 3, 2);
    e0 = exp_q.pop_front();
    void'(exp_q1.pop_front());
    total++;
    if (n != LAT) begin bad++; $display("FAIL restart_latency got=%0d want=%0d", n, LAT); end
    total++;
    if (got0 !== e0) begin bad++; $display("FAIL restart_result got=%b want=%b", got0, e0); end
  endtask

  task automatic test_back_to_back;
    int n;
    logic [7:0] e0, e1;
    phys0 = 4'b1110;
    phys1 = 4'b1110;
    launch(2'b00, 1'b1);
    wait_done(n, -1, 0);
    e0 = exp_q.pop_front();
    void'(exp_q1.pop_front());
    total++;
    if (n != LAT || got0 !== e0) begin
      bad++;
      $display("FAIL b2b_first got n=%0d res=%b want n=%0d res=%b", n, got0, LAT, e0);
    end
    // start still high during DONE; swap function, which only the retriggered run should use
    func_sel = 2'b11;
    @(negedge clk);
    total++;
    if ({busy0, done0, st0} !== 4'b0000) begin
      bad++;
      $display("FAIL b2b_idle_gap got busy,done,state=%b want=0000", {busy0, done0, st0});
    end
    exp_q.push_back(predict(2'b11, phys0, 7));
    exp_q1.push_back(predict(2'b11, phys1, 1));
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(n, -1, 0);
    e0 = exp_q.pop_front();
    e1 = exp_q1.pop_front();
    total++;
    if (n != LAT) begin bad++; $display("FAIL b2b_second_latency got=%0d want=%0d", n, LAT); end
    total++;
    if (got0 !== e0) begin bad++; $display("FAIL b2b_second_result0 got=%b want=%b", got0, e0); end
    total++;
    if (got1 !== e1) begin bad++; $display("FAIL b2b_second_result1 got=%b want=%b", got1, e1); end
  endtask

  task automatic test_reset_mid;
    int n;
    int seen_done;
    logic [7:0] e0;
    phys0 = 4'b0000;
    phys1 = 4'b0000;
    launch(2'b00, 1'b0);
    // This run is aborted, so its expectations are withdrawn.
    void'(exp_q.pop_back());
    void'(exp_q1.pop_back());
    for (int i = 0; i <= 7; i++) @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++;
    if ({busy0, done0, pass0, err_cnt0, fail_vec0, a0, b0, st0} !== 13'd0) begin
      bad++;
      $display("FAIL midreset_clear got=%b want=0", {busy0, done0, pass0, err_cnt0, fail_vec0, a0, b0, st0});
    end
    seen_done = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done0 || busy0) seen_done++;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3 * HOLD; i++) begin
      @(negedge clk);
      if (done0 || busy0) seen_done++;
    end
    total++;
    if (seen_done != 0) begin bad++; $display("FAIL midreset_activity got=%0d want=0", seen_done); end
    phys0 = 4'b1110;
    phys1 = 4'b1110;
    launch(2'b00, 1'b0);
    wait_done(n, -1, 0);
    e0 = exp_q.pop_front();
    void'(exp_q1.pop_front());
    total++;
    if (n != LAT || got0 !== e0) begin
      bad++;
      $display("FAIL midreset_fresh got n=%0d res=%b want n=%0d res=%b", n, got0, LAT, e0);
    end
  endtask

  initial begin
    test_reset();
    test_or_ideal();
    test_stuck0();
    test_func_change();
    test_saturation();
    test_nor_xor();
    test_busy_restart();
    test_back_to_back();
    test_reset_mid();
    total++;
    if (exp_q.size() != 0 || exp_q1.size() != 0) begin
      bad++;
      $display("FAIL queue_drain got=%0d,%0d want=0,0", exp_q.size(), exp_q1.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
